// File: rtl/pc_gen.sv
// Program-counter generator with redirect priority and an optional return-address stack.
// Define PC_GEN_RAS_EN to build the RAS; without it, ret loads ret_target and call acts as jmp.
module pc_gen #(
  parameter int          ADDR_W    = 32,
  parameter logic [63:0] RESET_VEC = 64'h0040_0000,
  parameter logic [63:0] EXC_VEC   = 64'h8000_0180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              exc_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic              call,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              ret,
  input  logic [ADDR_W-1:0] ret_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ras_empty,
  output logic              ras_full
);

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              ras_hit;
  logic [ADDR_W-1:0] ras_top;

  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + ADDR_W'(4);

  // Redirect priority: exception, resolved branch, stall hold, return, jump/call, sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (exc_req)             pc_d = align(EXC_VEC[ADDR_W-1:0]);
    else if (br_taken)       pc_d = align(br_target);
    else if (stall)          pc_d = pc_q;
    else if (ret)            pc_d = ras_hit ? align(ras_top) : align(ret_target);
    else if (jmp || call)    pc_d = align(jmp_target);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VEC[ADDR_W-1:0];
    else     pc_q <= pc_d;
  end

`ifdef PC_GEN_RAS_EN
  localparam int              PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;   // index of the most recent entry
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              ras_empty_q, ras_full_q;
  logic              do_ops, do_push, do_pop;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;

  assign ras_hit   = (cnt_q != '0);
  assign ras_top   = ras_mem[top_q];
  assign ras_empty = ras_empty_q;
  assign ras_full  = ras_full_q;

  assign do_ops  = !rst && !exc_req && !br_taken && !stall;
  assign do_push = do_ops && call;
  assign do_pop  = do_ops && ret;

  // Circular stack: a push when full lands on the oldest slot, which is top+1.
  always_comb begin
    cnt_d  = cnt_q;
    top_d  = top_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (exc_req) begin
      cnt_d = '0;
      top_d = '0;
    end else if (do_push && do_pop) begin
      wr_en = 1'b1;
      if (!ras_hit) begin
        top_d  = top_q + PTR_W'(1);
        wr_idx = top_q + PTR_W'(1);
        cnt_d  = (PTR_W+1)'(1);
      end
    end else if (do_push) begin
      wr_en  = 1'b1;
      top_d  = top_q + PTR_W'(1);
      wr_idx = top_q + PTR_W'(1);
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + (PTR_W+1)'(1);
    end else if (do_pop && ras_hit) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q       <= '0;
      cnt_q       <= '0;
      ras_empty_q <= 1'b1;
      ras_full_q  <= 1'b0;
    end else begin
      top_q       <= top_d;
      cnt_q       <= cnt_d;
      ras_empty_q <= (cnt_d == '0);
      ras_full_q  <= (cnt_d == DEPTH_C);
    end
  end

  // Entry storage carries no reset; validity comes from cnt_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_idx] <= pc_plus4;
  end
`else
  assign ras_hit   = 1'b0;
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, stall, exc_req, br_taken, jmp, call, ret;
  logic [31:0] br_target, jmp_target, ret_target;
  logic [31:0] pc_out, pc_plus4;
  logic        ras_empty, ras_full;

  logic        rst16;
  logic        z1 = 1'b0;
  logic [15:0] z16 = 16'h0;
  logic [15:0] pc16, pc16_p4;
  logic        e16, f16;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: architectural PC and the stack as a queue (back = top).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic [31:0] exp_q[$];

  pc_gen #(.ADDR_W(32), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .call(call),
    .jmp_target(jmp_target), .ret(ret), .ret_target(ret_target),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  pc_gen #(.ADDR_W(16), .RESET_VEC(64'hFFF0), .RAS_DEPTH(2)) dut16 (
    .clk(clk), .rst(rst16), .stall(z1), .exc_req(z1),
    .br_taken(z1), .br_target(z16), .jmp(z1), .call(z1),
    .jmp_target(z16), .ret(z1), .ret_target(z16),
    .pc_out(pc16), .pc_plus4(pc16_p4), .ras_empty(e16), .ras_full(f16)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ras_built();
`ifdef PC_GEN_RAS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (rst) begin
      m_pc = 32'h0040_0000;
      m_ras.delete();
    end else if (exc_req) begin
      m_pc = 32'h8000_0180;
      m_ras.delete();
    end else if (br_taken) begin
      m_pc = br_target & ~32'h3;
    end else if (!stall) begin
      if (ret) begin
        if (ras_built() && m_ras.size() > 0) m_pc = m_ras.pop_back();
        else                                 m_pc = ret_target & ~32'h3;
      end else if (jmp || call) begin
        m_pc = jmp_target & ~32'h3;
      end else begin
        m_pc = seq;
      end
      if (call && ras_built()) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
  endtask

  task automatic clear_inputs();
    rst = 0; stall = 0; exc_req = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
    br_target = 0; jmp_target = 0; ret_target = 32'h00BA_D000;
  endtask

  // driver: apply current inputs for one edge, then score the outputs
  task automatic tick(input string tag);
    logic [31:0] exp_pc;
    model_step();
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    exp_pc = exp_q.pop_front();
    check({tag, ".pc_out"}, 64'(pc_out), 64'(exp_pc));
    check({tag, ".pc_plus4"}, 64'(pc_plus4), 64'(exp_pc + 32'd4));
    check({tag, ".ras_empty"}, 64'(ras_empty), 64'(m_ras.size() == 0));
    check({tag, ".ras_full"}, 64'(ras_full), 64'(m_ras.size() == DEPTH));
  endtask

  initial begin
    clear_inputs();
    rst16 = 1;
    m_pc = 32'h0;

    // reset then three free-running cycles
    rst = 1; tick("reset");
    check("reset.const", 64'(pc_out), 64'h0040_0000);
    rst = 0;
    tick("seq1"); check("seq1.const", 64'(pc_out), 64'h0040_0004);
    tick("seq2"); check("seq2.const", 64'(pc_out), 64'h0040_0008);
    tick("seq3"); check("seq3.const", 64'(pc_out), 64'h0040_000C);
    tick("seq4");

    // call, four sequential, ret
    call = 1; jmp_target = 32'h0040_1000; tick("call");
    check("call.const", 64'(pc_out), 64'h0040_1000);
    call = 0;
    for (int i = 0; i < 4; i++) tick("body");
    check("body.const", 64'(pc_out), 64'h0040_1010);
    ret = 1; tick("ret");
    ret = 0;

    // five nested calls then five rets
    for (int i = 0; i < 5; i++) begin
      call = 1; jmp_target = 32'h0050_0000 + 32'(i) * 32'h100; tick("nest_call");
      call = 0; tick("nest_seq");
    end
    for (int i = 0; i < 5; i++) begin
      ret = 1; ret_target = 32'h0060_0000 + 32'(i) * 32'h10; tick("nest_ret");
    end
    ret = 0;

    // stall holds a jump; branch overrides the stall
    stall = 1; jmp = 1; jmp_target = 32'h0070_0000;
    for (int i = 0; i < 3; i++) tick("stall_jmp");
    br_taken = 1; br_target = 32'h0040_0203; tick("stall_br");
    check("stall_br.const", 64'(pc_out), 64'h0040_0200);
    stall = 0; jmp = 0; br_taken = 0;

    // exception beats branch and ret, clears the stack
    call = 1; jmp_target = 32'h0041_0000; tick("pre_call1");
    jmp_target = 32'h0042_0000; tick("pre_call2");
    call = 0;
    exc_req = 1; br_taken = 1; br_target = 32'h0043_0000; ret = 1; tick("exc");
    check("exc.const", 64'(pc_out), 64'h8000_0180);
    check("exc.empty", 64'(ras_empty), 64'h1);
    exc_req = 0; br_taken = 0; ret = 0;

    // ret and call together, on empty and non-empty stack
    ret = 1; call = 1; jmp_target = 32'h0044_0000; ret_target = 32'h0045_0007; tick("retcall_empty");
    ret = 0; call = 1; jmp_target = 32'h0046_0000; tick("push_one");
    ret = 1; call = 1; tick("retcall_full");
    call = 0; tick("ret_a"); tick("ret_b"); ret = 0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 79) == 0);
      exc_req    = ($urandom_range(0, 29) == 0);
      br_taken   = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 5) == 0);
      ret        = ($urandom_range(0, 4) == 0);
      call       = ($urandom_range(0, 4) == 0);
      jmp        = ($urandom_range(0, 7) == 0);
      br_target  = $urandom;
      jmp_target = $urandom;
      ret_target = $urandom;
      tick("rand");
    end
    clear_inputs();

    // 16-bit instance: sequential wrap from 0xFFFC to 0x0000
    rst16 = 1; @(posedge clk); #1;
    check("w16.reset", 64'(pc16), 64'hFFF0);
    rst16 = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("w16.top", 64'(pc16), 64'hFFFC);
    check("w16.p4", 64'(pc16_p4), 64'h0000);
    @(posedge clk); #1;
    check("w16.wrap", 64'(pc16), 64'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the program-counter width in bits (legal range 8..64).
REQ-002 Parameter RESET_VEC, default 32'h0040_0000, SHALL set the PC value loaded on reset.
REQ-003 Parameter EXC_VEC, default 32'h8000_0180, SHALL set the PC value loaded on exception.
REQ-004 Parameter RAS_DEPTH, default 4, SHALL set the return-address-stack entry count (power of two, 2..16).
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-007 stall  in  1  SHALL hold the PC and RAS when high, unless exc_req or br_taken is high.
REQ-008 exc_req  in  1  SHALL request a redirect to EXC_VEC.
REQ-009 br_taken  in  1, br_target  in  ADDR_W  SHALL request a resolved-branch redirect to br_target.
REQ-010 jmp  in  1, call  in  1, jmp_target  in  ADDR_W  SHALL request a jump; call additionally pushes the return address.
REQ-011 ret  in  1, ret_target  in  ADDR_W  SHALL request a return; ret_target is the architectural $ra value.
REQ-012 pc_out  out  ADDR_W  SHALL be the registered PC of the instruction fetched this cycle.
REQ-013 pc_plus4  out  ADDR_W  SHALL equal pc_out + 4 (combinational).
REQ-014 ras_empty  out  1, ras_full  out  1  SHALL report RAS occupancy, registered.

Function
REQ-015 Next-PC priority SHALL be: rst > exc_req > br_taken > stall (hold) > ret > jmp/call > sequential (pc_out + 4).
REQ-016 PC update latency SHALL be one cycle: a request sampled at edge N appears on pc_out after edge N.
REQ-017 All loaded targets SHALL have bits [1:0] forced to 0.
REQ-018 Sequential increment SHALL wrap modulo 2^ADDR_W (all-ones-minus-3 -> 0).
REQ-019 call SHALL push pc_plus4 onto the RAS and load jmp_target; jmp without call SHALL not touch the RAS.
REQ-020 ret SHALL load the RAS top and pop it when the RAS is non-empty, and load ret_target when the RAS is empty.
REQ-021 Push when full SHALL overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_full stays 1.
REQ-022 Pop when empty SHALL leave count at 0 (no underflow).
REQ-023 ret and call in the same cycle SHALL take the popped value as next PC and replace the top with pc_plus4; count unchanged (if empty: load ret_target, push pc_plus4, count 1).
REQ-024 exc_req SHALL clear the RAS (count 0) in the same cycle as the redirect.
REQ-025 br_taken SHALL NOT modify the RAS; ret/jmp/call in the same cycle as br_taken or exc_req SHALL be ignored.
REQ-026 While stall is high without exc_req/br_taken, pc_out, RAS contents and count SHALL hold.

Reset
REQ-027 On rst at a clock edge: pc_out = RESET_VEC, RAS count = 0, ras_empty = 1, ras_full = 0; all other inputs ignored.
REQ-028 rst asserted mid-operation SHALL discard any pending redirect and RAS content in that cycle.
REQ-029 RAS entry storage need not be reset; only the count and pointer SHALL be.

Configuration
REQ-030 Macro PC_GEN_RAS_EN defined: RAS is built per REQ-019..REQ-024.
REQ-031 Macro PC_GEN_RAS_EN undefined: no RAS storage; ret always loads ret_target, call acts as jmp, ras_empty tied 1, ras_full tied 0.

Verification
REQ-032 rst=1 one cycle, then 3 free cycles -> pc_out 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
REQ-033 At pc 0x00400010: call to 0x00401000, 4 cycles sequential, ret -> pc_out 0x00401000 ... 0x00401010, then 0x00400014; ras_empty 0->1.
REQ-034 RAS_DEPTH=4: five nested calls then five rets -> first four return addresses in LIFO order, fifth ret loads ret_target; ras_full high after fourth push.
REQ-035 stall=1 with jmp=1 for 3 cycles -> pc_out held; same cycle br_taken=1 target 0x00400203 -> pc_out 0x00400200 next cycle.
REQ-036 exc_req with br_taken, ret and 2 RAS entries -> pc_out 0x80000180, ras_empty 1.
REQ-037 ADDR_W=16, pc 0xFFFC sequential -> pc_out 0x0000; rebuild without PC_GEN_RAS_EN, call then ret -> ret loads ret_target.
